// File: rtl/main_fsm_ctrl.sv
// Multicycle RISC-V main control FSM: sequences fetch/decode/execute/memory/writeback
// and drives datapath strobes and mux selects from the current state.
module main_fsm_ctrl #(
   parameter bit MEM_WAIT_EN = 1'b1
) (
   input  logic       clk,
   input  logic       reset,
   input  logic [6:0] op,
   input  logic       zero,
   input  logic       memReady,
   output logic       pcWrite,
   output logic       adrSrc,
   output logic       irWrite,
   output logic       memWrite,
   output logic       regWrite,
   output logic [1:0] aluSrcA,
   output logic [1:0] aluSrcB,
   output logic [1:0] resultSrc,
   output logic [1:0] aluOp,
   output logic       illegalOp,
   output logic       instrDone,
   output logic [3:0] state
);

   typedef enum logic [3:0] {
      S_FETCH    = 4'd0,
      S_DECODE   = 4'd1,
      S_MEMADR   = 4'd2,
      S_MEMREAD  = 4'd3,
      S_MEMWB    = 4'd4,
      S_MEMWRITE = 4'd5,
      S_EXECR    = 4'd6,
      S_ALUWB    = 4'd7,
      S_EXECI    = 4'd8,
      S_JAL      = 4'd9,
      S_BEQ      = 4'd10
   } state_t;

   localparam logic [6:0] OP_LW   = 7'b0000011;
   localparam logic [6:0] OP_SW   = 7'b0100011;
   localparam logic [6:0] OP_R    = 7'b0110011;
   localparam logic [6:0] OP_I    = 7'b0010011;
   localparam logic [6:0] OP_JAL  = 7'b1101111;
   localparam logic [6:0] OP_BEQ  = 7'b1100011;

   state_t state_reg;
   logic   mem_ready;
   logic   pc_update;
   logic   branch;

   assign mem_ready = MEM_WAIT_EN ? memReady : 1'b1;

   always_ff @(posedge clk) begin
      if (reset) begin
         state_reg <= S_FETCH;
      end else begin
         case (state_reg)
            S_FETCH:    state_reg <= mem_ready ? S_DECODE : S_FETCH;
            S_DECODE: begin
               case (op)
                  OP_LW, OP_SW: state_reg <= S_MEMADR;
                  OP_R:         state_reg <= S_EXECR;
                  OP_I:         state_reg <= S_EXECI;
                  OP_JAL:       state_reg <= S_JAL;
                  OP_BEQ:       state_reg <= S_BEQ;
                  default:      state_reg <= S_FETCH;
               endcase
            end
            S_MEMADR:   state_reg <= (op == OP_LW) ? S_MEMREAD : S_MEMWRITE;
            S_MEMREAD:  state_reg <= mem_ready ? S_MEMWB : S_MEMREAD;
            S_MEMWB:    state_reg <= S_FETCH;
            S_MEMWRITE: state_reg <= mem_ready ? S_FETCH : S_MEMWRITE;
            S_EXECR:    state_reg <= S_ALUWB;
            S_EXECI:    state_reg <= S_ALUWB;
            S_ALUWB:    state_reg <= S_FETCH;
            S_JAL:      state_reg <= S_ALUWB;
            S_BEQ:      state_reg <= S_FETCH;
            default:    state_reg <= S_FETCH;
         endcase
      end
   end

   // Outputs depend on memReady in the wait states and must drop the same
   // cycle reset rises, so they are decoded combinationally from the state.
   always_comb begin
      pc_update = 1'b0;
      branch    = 1'b0;
      adrSrc    = 1'b0;
      irWrite   = 1'b0;
      memWrite  = 1'b0;
      regWrite  = 1'b0;
      aluSrcA   = 2'b00;
      aluSrcB   = 2'b00;
      resultSrc = 2'b00;
      aluOp     = 2'b00;
      illegalOp = 1'b0;
      instrDone = 1'b0;
      if (!reset) begin
         case (state_reg)
            S_FETCH: begin
               aluSrcB   = 2'b10;
               resultSrc = 2'b10;
               irWrite   = mem_ready;
               pc_update = mem_ready;
            end
            S_DECODE: begin
               aluSrcA = 2'b01;
               aluSrcB = 2'b01;
               case (op)
                  OP_LW, OP_SW, OP_R, OP_I, OP_JAL, OP_BEQ: illegalOp = 1'b0;
                  default:                                  illegalOp = 1'b1;
               endcase
            end
            S_MEMADR: begin
               aluSrcA = 2'b10;
               aluSrcB = 2'b01;
            end
            S_MEMREAD: adrSrc = 1'b1;
            S_MEMWB: begin
               resultSrc = 2'b01;
               regWrite  = 1'b1;
               instrDone = 1'b1;
            end
            S_MEMWRITE: begin
               adrSrc    = 1'b1;
               memWrite  = 1'b1;
               instrDone = mem_ready;
            end
            S_EXECR: begin
               aluSrcA = 2'b10;
               aluOp   = 2'b10;
            end
            S_EXECI: begin
               aluSrcA = 2'b10;
               aluSrcB = 2'b01;
               aluOp   = 2'b10;
            end
            S_ALUWB: begin
               regWrite  = 1'b1;
               instrDone = 1'b1;
            end
            // Link write happens in the following ALUWB, which signals completion.
            S_JAL: begin
               aluSrcA   = 2'b01;
               aluSrcB   = 2'b10;
               pc_update = 1'b1;
            end
            S_BEQ: begin
               aluSrcA   = 2'b10;
               aluOp     = 2'b01;
               branch    = 1'b1;
               instrDone = 1'b1;
            end
            default: ;
         endcase
      end
      pcWrite = pc_update | (branch & zero);
   end

   assign state = reset ? 4'd0 : state_reg;

endmodule

// File: tb/tb_main_fsm_ctrl.sv
// Directed bench for main_fsm_ctrl: stimulus pushes per-cycle expected outputs
// into a scoreboard queue, a negedge monitor pops and compares.
module tb_main_fsm_ctrl;

   logic       clk = 1'b0;
   logic       reset;
   logic [6:0] op;
   logic       zero;
   logic       memReady;
   logic       pcWrite, adrSrc, irWrite, memWrite, regWrite;
   logic [1:0] aluSrcA, aluSrcB, resultSrc, aluOp;
   logic       illegalOp, instrDone;
   logic [3:0] state;

   localparam logic [6:0] OP_LW  = 7'b0000011;
   localparam logic [6:0] OP_SW  = 7'b0100011;
   localparam logic [6:0] OP_R   = 7'b0110011;
   localparam logic [6:0] OP_I   = 7'b0010011;
   localparam logic [6:0] OP_JAL = 7'b1101111;
   localparam logic [6:0] OP_BEQ = 7'b1100011;
   localparam logic [6:0] OP_BAD = 7'b1111111;

   typedef struct {
      logic [18:0] vec;
      string       name;
   } exp_t;

   exp_t sb_q[$];
   int   total = 0;
   int   bad   = 0;

   always #5 clk = ~clk;

   main_fsm_ctrl #(.MEM_WAIT_EN(1'b1)) dut (
      .clk(clk), .reset(reset), .op(op), .zero(zero), .memReady(memReady),
      .pcWrite(pcWrite), .adrSrc(adrSrc), .irWrite(irWrite), .memWrite(memWrite),
      .regWrite(regWrite), .aluSrcA(aluSrcA), .aluSrcB(aluSrcB),
      .resultSrc(resultSrc), .aluOp(aluOp), .illegalOp(illegalOp),
      .instrDone(instrDone), .state(state)
   );

   // {state, pcWrite, adrSrc, irWrite, memWrite, regWrite, aluSrcA, aluSrcB, resultSrc, aluOp, illegalOp, instrDone}
   function automatic logic [18:0] ev(input logic [3:0] st, input logic pcw, input logic adr,
                                      input logic irw, input logic mw, input logic rw,
                                      input logic [1:0] sa, input logic [1:0] sb,
                                      input logic [1:0] rs, input logic [1:0] ao,
                                      input logic ill, input logic done);
      return {st, pcw, adr, irw, mw, rw, sa, sb, rs, ao, ill, done};
   endfunction

   function automatic logic [18:0] e_fetch(input logic mr);
      return ev(4'd0, mr, 1'b0, mr, 1'b0, 1'b0, 2'b00, 2'b10, 2'b10, 2'b00, 1'b0, 1'b0);
   endfunction
   function automatic logic [18:0] e_decode(input logic ill);
      return ev(4'd1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b01, 2'b01, 2'b00, 2'b00, ill, 1'b0);
   endfunction
   function automatic logic [18:0] e_memadr();
      return ev(4'd2, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b10, 2'b01, 2'b00, 2'b00, 1'b0, 1'b0);
   endfunction
   function automatic logic [18:0] e_memread();
      return ev(4'd3, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 2'b00, 2'b00, 2'b00, 2'b00, 1'b0, 1'b0);
   endfunction
   function automatic logic [18:0] e_memwb();
      return ev(4'd4, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 2'b00, 2'b00, 2'b01, 2'b00, 1'b0, 1'b1);
   endfunction
   function automatic logic [18:0] e_memwrite(input logic mr);
      return ev(4'd5, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 2'b00, 2'b00, 2'b00, 2'b00, 1'b0, mr);
   endfunction
   function automatic logic [18:0] e_execr();
      return ev(4'd6, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b10, 2'b00, 2'b00, 2'b10, 1'b0, 1'b0);
   endfunction
   function automatic logic [18:0] e_aluwb();
      return ev(4'd7, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 2'b00, 2'b00, 2'b00, 2'b00, 1'b0, 1'b1);
   endfunction
   function automatic logic [18:0] e_execi();
      return ev(4'd8, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b10, 2'b01, 2'b00, 2'b10, 1'b0, 1'b0);
   endfunction
   function automatic logic [18:0] e_jal();
      return ev(4'd9, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 2'b01, 2'b10, 2'b00, 2'b00, 1'b0, 1'b0);
   endfunction
   function automatic logic [18:0] e_beq(input logic z);
      return ev(4'd10, z, 1'b0, 1'b0, 1'b0, 1'b0, 2'b10, 2'b00, 2'b00, 2'b01, 1'b0, 1'b1);
   endfunction

   // Apply one cycle of inputs, record what the DUT must show this cycle, advance.
   task automatic step(input logic rst, input logic [6:0] opc, input logic z,
                       input logic mr, input logic [18:0] expv, input string name);
      exp_t e;
      reset    = rst;
      op       = opc;
      zero     = z;
      memReady = mr;
      e.vec    = expv;
      e.name   = name;
      sb_q.push_back(e);
      @(posedge clk);
      #1;
   endtask

   always @(negedge clk) begin
      exp_t        e;
      logic [18:0] got;
      if (sb_q.size() > 0) begin
         e   = sb_q.pop_front();
         got = {state, pcWrite, adrSrc, irWrite, memWrite, regWrite,
                aluSrcA, aluSrcB, resultSrc, aluOp, illegalOp, instrDone};
         total++;
         if (got !== e.vec) begin
            bad++;
            $display("FAIL %s: got=%05h want=%05h", e.name, got, e.vec);
         end else begin
            $display("ok   %s: outputs=%05h", e.name, got);
         end
      end
   end

   initial begin
      reset = 1'b1; op = 7'd0; zero = 1'b0; memReady = 1'b1;
      @(posedge clk);
      #1;
      // reset held two cycles, then add
      step(1'b1, OP_R, 1'b0, 1'b1, 19'd0, "reset0");
      step(1'b1, OP_R, 1'b0, 1'b1, 19'd0, "reset1");
      step(1'b0, OP_R, 1'b0, 1'b1, e_fetch(1'b1), "add_fetch");
      step(1'b0, OP_R, 1'b0, 1'b1, e_decode(1'b0), "add_decode");
      step(1'b0, OP_R, 1'b0, 1'b1, e_execr(), "add_execr");
      step(1'b0, OP_R, 1'b0, 1'b1, e_aluwb(), "add_aluwb");
      // lw with fetch and read wait states; op wiggles in MEMREAD
      step(1'b0, OP_LW, 1'b0, 1'b0, e_fetch(1'b0), "lw_fetch_wait0");
      step(1'b0, OP_LW, 1'b0, 1'b0, e_fetch(1'b0), "lw_fetch_wait1");
      step(1'b0, OP_LW, 1'b0, 1'b1, e_fetch(1'b1), "lw_fetch");
      step(1'b0, OP_LW, 1'b0, 1'b1, e_decode(1'b0), "lw_decode");
      step(1'b0, OP_LW, 1'b0, 1'b1, e_memadr(), "lw_memadr");
      step(1'b0, OP_BAD, 1'b0, 1'b0, e_memread(), "lw_memread_wait");
      step(1'b0, OP_SW, 1'b0, 1'b1, e_memread(), "lw_memread");
      step(1'b0, OP_R, 1'b0, 1'b1, e_memwb(), "lw_memwb");
      // sw with one write wait state
      step(1'b0, OP_SW, 1'b0, 1'b1, e_fetch(1'b1), "sw_fetch");
      step(1'b0, OP_SW, 1'b0, 1'b1, e_decode(1'b0), "sw_decode");
      step(1'b0, OP_SW, 1'b0, 1'b1, e_memadr(), "sw_memadr");
      step(1'b0, OP_LW, 1'b0, 1'b0, e_memwrite(1'b0), "sw_memwrite_wait");
      step(1'b0, OP_LW, 1'b0, 1'b1, e_memwrite(1'b1), "sw_memwrite");
      // I-type
      step(1'b0, OP_I, 1'b0, 1'b1, e_fetch(1'b1), "addi_fetch");
      step(1'b0, OP_I, 1'b0, 1'b1, e_decode(1'b0), "addi_decode");
      step(1'b0, OP_I, 1'b0, 1'b1, e_execi(), "addi_execi");
      step(1'b0, OP_I, 1'b0, 1'b1, e_aluwb(), "addi_aluwb");
      // beq taken then not taken
      step(1'b0, OP_BEQ, 1'b1, 1'b1, e_fetch(1'b1), "beq1_fetch");
      step(1'b0, OP_BEQ, 1'b1, 1'b1, e_decode(1'b0), "beq1_decode");
      step(1'b0, OP_BEQ, 1'b1, 1'b1, e_beq(1'b1), "beq1_taken");
      step(1'b0, OP_BEQ, 1'b0, 1'b1, e_fetch(1'b1), "beq0_fetch");
      step(1'b0, OP_BEQ, 1'b0, 1'b1, e_decode(1'b0), "beq0_decode");
      step(1'b0, OP_BEQ, 1'b0, 1'b1, e_beq(1'b0), "beq0_not_taken");
      // jal
      step(1'b0, OP_JAL, 1'b0, 1'b1, e_fetch(1'b1), "jal_fetch");
      step(1'b0, OP_JAL, 1'b0, 1'b1, e_decode(1'b0), "jal_decode");
      step(1'b0, OP_JAL, 1'b0, 1'b1, e_jal(), "jal_jal");
      step(1'b0, OP_JAL, 1'b0, 1'b1, e_aluwb(), "jal_aluwb");
      // illegal opcode
      step(1'b0, OP_BAD, 1'b0, 1'b1, e_fetch(1'b1), "ill_fetch");
      step(1'b0, OP_BAD, 1'b0, 1'b1, e_decode(1'b1), "ill_decode");
      // reset while stalled in MEMWRITE
      step(1'b0, OP_SW, 1'b0, 1'b1, e_fetch(1'b1), "rst_sw_fetch");
      step(1'b0, OP_SW, 1'b0, 1'b1, e_decode(1'b0), "rst_sw_decode");
      step(1'b0, OP_SW, 1'b0, 1'b1, e_memadr(), "rst_sw_memadr");
      step(1'b0, OP_SW, 1'b0, 1'b0, e_memwrite(1'b0), "rst_sw_memwrite");
      step(1'b1, OP_SW, 1'b0, 1'b1, 19'd0, "rst_sw_reset");
      step(1'b0, OP_SW, 1'b0, 1'b1, e_fetch(1'b1), "rst_sw_refetch");
      step(1'b0, OP_SW, 1'b0, 1'b1, e_decode(1'b0), "rst_sw_redecode");

      for (int i = 0; i < 10 && sb_q.size() > 0; i++) @(posedge clk);
      if (sb_q.size() > 0) begin
         total++;
         bad++;
         $display("FAIL drain: got=%0d pending want=0", sb_q.size());
      end
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

   initial begin
      #100000;
      $display("FAIL timeout: got=running want=finished");
      $fatal(1, "timeout");
   end

endmodule
